// File: rtl/sobel_3_3.sv
// sobel_3_3: 3x3 Sobel gradient magnitude with border substitution.
// Consumes one 3x3 window per cycle and produces |Gx|+|Gy| saturated to
// 8 bits plus a thresholded edge flag, with a fixed 3-cycle latency.
// Windows whose centre lies on the image edge output a border value instead.
//
// Ports:
//   iclk       pixel clock
//   rst_i      synchronous active-high reset
//   ivalid     window valid (centre pixel valid)
//   idata_3_3  window {p11,p12,p13,p21,p22,p23,p31,p32,p33}, p11 in [71:64]
//   ovalid     result valid (ivalid delayed by 3)
//   odata      saturated gradient magnitude, or border value
//   oedge      odata >= THRESH on interior pixels, 0 on border pixels
module sobel_3_3 #(
   parameter int unsigned IMG_W       = 720,
   parameter int unsigned IMG_H       = 576,
   parameter int unsigned THRESH      = 128,
   parameter bit          BORDER_MODE = 1'b0
) (
   input  logic        iclk,
   input  logic        rst_i,
   input  logic        ivalid,
   input  logic [71:0] idata_3_3,
   output logic        ovalid,
   output logic [7:0]  odata,
   output logic        oedge
);

   localparam int unsigned PIX_W = 8;
   localparam int unsigned SUM_W = 10;
   localparam int unsigned MAG_W = 11;
   localparam int unsigned COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
   localparam int unsigned ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;

   localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
   localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);
   localparam logic [PIX_W-1:0] THRESH_8 = PIX_W'(THRESH);
   localparam logic [MAG_W-1:0] SAT_MAX  = MAG_W'(255);

   // Window unpack
   logic [PIX_W-1:0] p11, p12, p13, p21, p22, p23, p31, p32, p33;
   assign {p11, p12, p13, p21, p22, p23, p31, p32, p33} = idata_3_3;

   // Weighted column/row sums (each fits in 10 bits, max 1020)
   logic [SUM_W-1:0] sum_l_c, sum_r_c, sum_t_c, sum_b_c;
   assign sum_l_c = SUM_W'(p11) + (SUM_W'(p21) << 1) + SUM_W'(p31);
   assign sum_r_c = SUM_W'(p13) + (SUM_W'(p23) << 1) + SUM_W'(p33);
   assign sum_t_c = SUM_W'(p11) + (SUM_W'(p12) << 1) + SUM_W'(p13);
   assign sum_b_c = SUM_W'(p31) + (SUM_W'(p32) << 1) + SUM_W'(p33);

   // Position counters: advance only on valid windows, hold through gaps
   logic [COL_W-1:0] col;
   logic [ROW_W-1:0] row;

   always_ff @(posedge iclk) begin
      if (rst_i) begin
         col <= '0;
         row <= '0;
      end else if (ivalid) begin
         if (col == COL_LAST) begin
            col <= '0;
            row <= (row == ROW_LAST) ? '0 : row + ROW_W'(1);
         end else begin
            col <= col + COL_W'(1);
         end
      end
   end

   // Border flag from the pre-increment position of this window's centre
   logic border_c;
   assign border_c = (col == '0) || (col == COL_LAST) ||
                     (row == '0) || (row == ROW_LAST);

   // S1: weighted sums, centre pixel, border flag
   logic             s1_valid;
   logic [SUM_W-1:0] s1_sum_l, s1_sum_r, s1_sum_t, s1_sum_b;
   logic [PIX_W-1:0] s1_center;
   logic             s1_border;

   always_ff @(posedge iclk) begin
      if (rst_i) begin
         s1_valid <= 1'b0;
      end else begin
         s1_valid <= ivalid;
      end
      s1_sum_l  <= sum_l_c;
      s1_sum_r  <= sum_r_c;
      s1_sum_t  <= sum_t_c;
      s1_sum_b  <= sum_b_c;
      s1_center <= p22;
      s1_border <= border_c;
   end

   // S2: absolute gradients as larger-minus-smaller
   logic             s2_valid;
   logic [SUM_W-1:0] s2_gx, s2_gy;
   logic [PIX_W-1:0] s2_center;
   logic             s2_border;

   always_ff @(posedge iclk) begin
      if (rst_i) begin
         s2_valid <= 1'b0;
      end else begin
         s2_valid <= s1_valid;
      end
      s2_gx     <= (s1_sum_r >= s1_sum_l) ? (s1_sum_r - s1_sum_l) : (s1_sum_l - s1_sum_r);
      s2_gy     <= (s1_sum_b >= s1_sum_t) ? (s1_sum_b - s1_sum_t) : (s1_sum_t - s1_sum_b);
      s2_center <= s1_center;
      s2_border <= s1_border;
   end

   // S3: add, saturate, threshold, border mux
   logic [MAG_W-1:0] mag_c;
   logic [PIX_W-1:0] sat_c;
   assign mag_c = MAG_W'(s2_gx) + MAG_W'(s2_gy);
   assign sat_c = (mag_c > SAT_MAX) ? {PIX_W{1'b1}} : mag_c[PIX_W-1:0];

   always_ff @(posedge iclk) begin
      if (rst_i) begin
         ovalid <= 1'b0;
         odata  <= '0;
         oedge  <= 1'b0;
      end else if (s2_valid) begin
         ovalid <= 1'b1;
         if (s2_border) begin
            odata <= BORDER_MODE ? s2_center : '0;
            oedge <= 1'b0;
         end else begin
            odata <= sat_c;
            oedge <= (sat_c >= THRESH_8);
         end
      end else begin
         ovalid <= 1'b0;
         odata  <= '0;
         oedge  <= 1'b0;
      end
   end

endmodule

// File: tb/tb_sobel_3_3.sv
// Scoreboard bench for sobel_3_3: two instances on an 8x4 image
// (threshold 128 / border zero, threshold 0x28 / border centre pixel)
// share one stimulus stream; expected results are queued at issue time
// and checked by an independent output monitor.
module tb_sobel_3_3;

   localparam int W     = 8;
   localparam int H     = 4;
   localparam int THR_A = 128;
   localparam int THR_B = 40;

   logic        iclk   = 1'b0;
   logic        rst_i  = 1'b1;
   logic        ivalid = 1'b0;
   logic [71:0] idata  = '0;
   logic        ovalid_a, oedge_a, ovalid_b, oedge_b;
   logic [7:0]  odata_a, odata_b;

   always #5 iclk = ~iclk;

   sobel_3_3 #(.IMG_W(W), .IMG_H(H), .THRESH(THR_A), .BORDER_MODE(1'b0)) dut_a (
      .iclk(iclk), .rst_i(rst_i), .ivalid(ivalid), .idata_3_3(idata),
      .ovalid(ovalid_a), .odata(odata_a), .oedge(oedge_a));

   sobel_3_3 #(.IMG_W(W), .IMG_H(H), .THRESH(THR_B), .BORDER_MODE(1'b1)) dut_b (
      .iclk(iclk), .rst_i(rst_i), .ivalid(ivalid), .idata_3_3(idata),
      .ovalid(ovalid_b), .odata(odata_b), .oedge(oedge_b));

   typedef struct {
      int         cyc;
      logic [7:0] data;
      logic       flag;
   } exp_t;

   exp_t qa[$];
   exp_t qb[$];
   int   cyc        = 0;
   int   n          = 0;
   int   vectors    = 0;
   int   miscompares = 0;

   always @(posedge iclk) cyc <= cyc + 1;

   // Reference: Sobel on a 3x3 window at linear pixel index pos of a WxH frame
   function automatic exp_t model(input logic [71:0] w, input int pos,
                                  input int thr, input bit mode, input int at);
      exp_t e;
      int   p[9];
      int   l, r, t, b, gx, gy, mag, col, row;
      for (int i = 0; i < 9; i++) p[i] = int'(w[71-8*i -: 8]);
      l  = p[0] + 2*p[3] + p[6];
      r  = p[2] + 2*p[5] + p[8];
      t  = p[0] + 2*p[1] + p[2];
      b  = p[6] + 2*p[7] + p[8];
      gx = (r > l) ? r - l : l - r;
      gy = (b > t) ? b - t : t - b;
      mag = gx + gy;
      if (mag > 255) mag = 255;
      col = pos % W;
      row = (pos / W) % H;
      e.cyc = at;
      if (col == 0 || col == W-1 || row == 0 || row == H-1) begin
         e.data = mode ? 8'(p[4]) : 8'h00;
         e.flag = 1'b0;
      end else begin
         e.data = 8'(mag);
         e.flag = (mag >= thr);
      end
      return e;
   endfunction

   function automatic logic [71:0] rnd_win();
      logic [95:0] t;
      t = {$urandom(), $urandom(), $urandom()};
      return t[71:0];
   endfunction

   // One window per call; with_rst also asserts reset on the same edge
   task automatic drive(input logic [71:0] w, input bit with_rst);
      @(posedge iclk);
      #1;
      ivalid = 1'b1;
      idata  = w;
      rst_i  = with_rst;
      if (with_rst) begin
         qa.delete();
         qb.delete();
         n = 0;
      end else begin
         qa.push_back(model(w, n, THR_A, 1'b0, cyc + 3));
         qb.push_back(model(w, n, THR_B, 1'b1, cyc + 3));
         n++;
      end
   endtask

   task automatic idle(input int k);
      repeat (k) begin
         @(posedge iclk);
         #1;
         ivalid = 1'b0;
         rst_i  = 1'b0;
         idata  = rnd_win();
      end
   endtask

   task automatic chk(input int idx, input logic ov, input logic [7:0] od, input logic oe);
      exp_t e;
      int   sz;
      sz = (idx == 0) ? qa.size() : qb.size();
      // Anything overdue was never presented
      while (sz > 0) begin
         e = (idx == 0) ? qa[0] : qb[0];
         if (e.cyc >= cyc) break;
         vectors++;
         miscompares++;
         $display("FAIL missing dut%0d: no result at cyc %0d, want data=%02h edge=%0b",
                  idx, e.cyc, e.data, e.flag);
         if (idx == 0) void'(qa.pop_front()); else void'(qb.pop_front());
         sz--;
      end
      if (ov === 1'b1) begin
         vectors++;
         if (sz == 0) begin
            miscompares++;
            $display("FAIL unexpected dut%0d: got ovalid=1 data=%02h at cyc %0d, want ovalid=0",
                     idx, od, cyc);
         end else begin
            if (idx == 0) e = qa.pop_front(); else e = qb.pop_front();
            if (e.cyc != cyc || od !== e.data || oe !== e.flag) begin
               miscompares++;
               $display("FAIL result dut%0d: got data=%02h edge=%0b cyc=%0d, want data=%02h edge=%0b cyc=%0d",
                        idx, od, oe, cyc, e.data, e.flag, e.cyc);
            end
         end
      end else begin
         vectors++;
         if (ov !== 1'b0 || od !== 8'h00 || oe !== 1'b0) begin
            miscompares++;
            $display("FAIL idle dut%0d: got ovalid=%0b data=%02h edge=%0b at cyc %0d, want 0/00/0",
                     idx, ov, od, oe, cyc);
         end
      end
   endtask

   always @(negedge iclk) begin
      chk(0, ovalid_a, odata_a, oedge_a);
      chk(1, ovalid_b, odata_b, oedge_b);
   end

   initial begin
      // Reset state
      rst_i = 1'b1;
      repeat (2) @(posedge iclk);
      @(negedge iclk);
      vectors++;
      if (ovalid_a !== 1'b0 || odata_a !== 8'h00 || oedge_a !== 1'b0 ||
          ovalid_b !== 1'b0 || odata_b !== 8'h00 || oedge_b !== 1'b0) begin
         miscompares++;
         $display("FAIL reset: got a=%0b/%02h/%0b b=%0b/%02h/%0b, want all zero",
                  ovalid_a, odata_a, oedge_a, ovalid_b, odata_b, oedge_b);
      end
      idle(2);

      // Frame 1: 9 back-to-back, then directed interior windows at (1,1),(2,1),(3,1)
      for (int i = 0; i < 9; i++) drive(rnd_win(), 1'b0);
      drive({9{8'h50}}, 1'b0);
      drive({8'h00, 8'h00, 8'hFF, 8'h00, 8'h00, 8'hFF, 8'h00, 8'h00, 8'hFF}, 1'b0);
      drive({8'h00, 8'h00, 8'h0A, 8'h00, 8'h00, 8'h0A, 8'h00, 8'h00, 8'h0A}, 1'b0);
      // Rest of the 32-pixel frame with 0-3 cycle gaps, then the wrap to (0,0)
      for (int i = 0; i < 21; i++) begin
         drive(rnd_win(), 1'b0);
         idle(int'($urandom_range(0, 3)));
      end
      idle(6);

      // 100 back-to-back windows
      for (int i = 0; i < 100; i++) drive(rnd_win(), 1'b0);
      idle(6);

      // Three windows in flight when reset hits; none may emerge
      drive(rnd_win(), 1'b0);
      drive(rnd_win(), 1'b0);
      qa.delete();
      qb.delete();
      drive(rnd_win(), 1'b1);
      idle(5);

      // First window after reset is at (0,0), then more traffic with gaps
      drive({8'h11, 8'h22, 8'h33, 8'h44, 8'h5A, 8'h66, 8'h77, 8'h88, 8'h99}, 1'b0);
      for (int i = 0; i < 20; i++) begin
         drive(rnd_win(), 1'b0);
         idle(int'($urandom_range(0, 2)));
      end
      idle(8);

      vectors++;
      if (qa.size() != 0 || qb.size() != 0) begin
         miscompares++;
         $display("FAIL drain: got %0d/%0d results outstanding, want 0/0", qa.size(), qb.size());
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
